alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the issue queue.
- Per bank, accepts one issued ALU op (cmd, op1, op2, phys_rd), computes the 32-bit result, and registers it.
- Presents the result as a writeback beat (valid/phys_rd/data) toward the register file; the same beat feeds back as the issue queue's wakeup/writeback input.
- Each bank has a 2-entry buffer (output register plus skid register) so the writeback port can back-pressure without losing ops.

Parameters:
- DISPATCH_WIDTH, from parameters package: number of independent lanes.
- PHYS_REGS_ADDR_WIDTH, from parameters package: physical register tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low; asserted when 0, sampled on rising clk.
- issue_valid  in  [DISPATCH_WIDTH] x 1  issued op present on lane.
- issue_ready  out  [DISPATCH_WIDTH] x 1  lane can accept an op this cycle.
- issue_alu_cmd  in  [DISPATCH_WIDTH] x common::alu_cmd_t  operation.
- issue_op1  in  [DISPATCH_WIDTH] x 32  operand 1.
- issue_op2  in  [DISPATCH_WIDTH] x 32  operand 2.
- issue_phys_rd  in  [DISPATCH_WIDTH] x PHYS_REGS_ADDR_WIDTH  destination tag.
- wb_valid  out  [DISPATCH_WIDTH] x 1  result beat valid.
- wb_ready  in  [DISPATCH_WIDTH] x 1  writeback port accepts beat.
- wb_phys_rd  out  [DISPATCH_WIDTH] x PHYS_REGS_ADDR_WIDTH  destination tag of beat.
- wb_data  out  [DISPATCH_WIDTH] x 32  result of beat.

Behaviour:
- Lanes are fully independent; no cross-lane ordering.
- Handshakes:
  - Issue accept occurs when issue_valid && issue_ready.
  - Writeback transfer occurs when wb_valid && wb_ready.
- Result computed combinationally from issue inputs in the accept cycle; registered into the lane buffer.
- Latency: result appears on wb_* in the cycle after accept (1 cycle).
- ALU arithmetic, by common::alu_cmd_t member:
  - ADD, SUB: modulo 2^32.
  - SLL/SRL/SRA: shift amount op2[4:0]; SRA is arithmetic on op1.
  - SLT (signed), SLTU (unsigned): zero-extended 0/1 result.
  - XOR, OR, AND: bitwise.
  - Any other value: result 32'h0, beat still produced.
- Per-lane buffer states: EMPTY, ONE (output reg valid), TWO (output + skid valid).
  - EMPTY: accept -> ONE.
  - ONE:
    - accept && transfer -> ONE, with the new result in the output reg.
    - accept && !transfer -> TWO, with the new result in the skid reg.
    - !accept && transfer -> EMPTY.
    - otherwise hold.
  - TWO: accept impossible.
    - transfer -> ONE; skid moves into the output reg the same edge.
    - otherwise hold.
- issue_ready = (state != TWO). Driven from state registers only; no combinational path from wb_ready to issue_ready.
- wb_valid = (state != EMPTY). wb_phys_rd/wb_data come from the output reg.
- Output stability: wb_phys_rd/wb_data stay constant while wb_valid && !wb_ready.
- Order: FIFO within a lane; the skid entry never overtakes the output entry.
- Reset (rst==0 at an edge):
  - All lanes go to EMPTY, so wb_valid=0 and issue_ready=1 from the following cycle.
  - wb_phys_rd and wb_data are 0.
  - Reset mid-operation discards buffered results; no beat is emitted for them.
- issue_valid while issue_ready=0 is ignored; the upstream issue queue must hold the op.

Optional Feature:
- Macro: ALU_EXEC_PERF_CNT_EN.
- Defined: adds two outputs, perf_exec_count[31:0] and perf_stall_count[31:0].
  - perf_exec_count increments once per writeback transfer, summed over all lanes in the cycle.
  - perf_stall_count increments by the number of lanes with issue_valid && !issue_ready in the cycle.
  - Both counters wrap at 2^32 and are cleared by reset.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Lane0 issues ADD op1=32'hFFFF_FFFF, op2=1, phys_rd=5, wb_ready=1 -> next cycle wb_valid[0]=1, wb_phys_rd=5, wb_data=0; following cycle wb_valid=0.
- SRA op1=32'h8000_0000, op2=32'h0000_0024 (shamt 4) -> wb_data=32'hF800_0000. SLT op1=-1, op2=1 -> 1. SLTU same operands -> 0.
- wb_ready=0 and three back-to-back issues with tags 1, 2, 3 -> tags 1 and 2 accepted; issue_ready=0 during tag 3; wb shows tag 1 stable. Raise wb_ready -> beats 1, 2, 3 emerge in order with no loss or duplication.
- Both lanes stream every cycle with wb_ready=1 -> sustained 1 op/cycle/lane and issue_ready constant 1.
- Buffer in state TWO, then rst=0 for one cycle -> next cycle wb_valid all 0, issue_ready all 1, and no stale beat after release.
- With ALU_EXEC_PERF_CNT_EN defined, 10 transfers plus 3 lane-stall cycles -> perf_exec_count=10 and perf_stall_count=3; both read 0 after reset.

Source files
------------

// File: rtl/alu_exec_stage.sv
// ALU execute stage: per-lane ALU with a 2-entry writeback buffer.
// Optional ALU_EXEC_PERF_CNT_EN adds exec/stall performance counters.
package parameters;
    localparam int DISPATCH_WIDTH       = 2;
    localparam int PHYS_REGS_ADDR_WIDTH = 6;
endpackage

package common;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SRL  = 4'd3,
        ALU_SRA  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_cmd_t;
endpackage

module alu_exec_stage #(
    parameter int DISPATCH_WIDTH       = parameters::DISPATCH_WIDTH,
    parameter int PHYS_REGS_ADDR_WIDTH = parameters::PHYS_REGS_ADDR_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            issue_valid   [DISPATCH_WIDTH],
    output logic                            issue_ready   [DISPATCH_WIDTH],
    input  common::alu_cmd_t                issue_alu_cmd [DISPATCH_WIDTH],
    input  logic [31:0]                     issue_op1     [DISPATCH_WIDTH],
    input  logic [31:0]                     issue_op2     [DISPATCH_WIDTH],
    input  logic [PHYS_REGS_ADDR_WIDTH-1:0] issue_phys_rd [DISPATCH_WIDTH],
    output logic                            wb_valid      [DISPATCH_WIDTH],
    input  logic                            wb_ready      [DISPATCH_WIDTH],
    output logic [PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd    [DISPATCH_WIDTH],
    output logic [31:0]                     wb_data       [DISPATCH_WIDTH]
`ifdef ALU_EXEC_PERF_CNT_EN
    ,
    output logic [31:0]                     perf_exec_count,
    output logic [31:0]                     perf_stall_count
`endif
);
    import common::*;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;

    function automatic logic [31:0] alu(alu_cmd_t cmd, logic [31:0] a, logic [31:0] b);
        unique case (cmd)
            ALU_ADD:  alu = a + b;
            ALU_SUB:  alu = a - b;
            ALU_SLL:  alu = a << b[4:0];
            ALU_SRL:  alu = a >> b[4:0];
            ALU_SRA:  alu = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  alu = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: alu = {31'd0, a < b};
            ALU_XOR:  alu = a ^ b;
            ALU_OR:   alu = a | b;
            ALU_AND:  alu = a & b;
            default:  alu = 32'h0;
        endcase
    endfunction

    for (genvar i = 0; i < DISPATCH_WIDTH; i++) begin : g_lane
        buf_state_t                      state, state_nxt;
        logic [PHYS_REGS_ADDR_WIDTH-1:0] out_rd, skid_rd;
        logic [31:0]                     out_data, skid_data, result;
        logic                            accept, xfer;
        logic                            load_out_new, load_out_skid, load_skid;

        assign result = alu(issue_alu_cmd[i], issue_op1[i], issue_op2[i]);
        assign accept = issue_valid[i] && issue_ready[i];
        assign xfer   = wb_valid[i] && wb_ready[i];

        always_comb begin
            state_nxt     = state;
            load_out_new  = 1'b0;
            load_out_skid = 1'b0;
            load_skid     = 1'b0;
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt    = ONE;
                        load_out_new = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && xfer) begin
                        load_out_new = 1'b1;
                    end else if (accept) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (xfer) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (xfer) begin
                        state_nxt     = ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                state     <= EMPTY;
                out_rd    <= '0;
                out_data  <= '0;
                skid_rd   <= '0;
                skid_data <= '0;
            end else begin
                state <= state_nxt;
                if (load_out_new) begin
                    out_rd   <= issue_phys_rd[i];
                    out_data <= result;
                end else if (load_out_skid) begin
                    out_rd   <= skid_rd;
                    out_data <= skid_data;
                end
                if (load_skid) begin
                    skid_rd   <= issue_phys_rd[i];
                    skid_data <= result;
                end
            end
        end

        // Ready depends on state only, so wb_ready never reaches issue_ready.
        assign issue_ready[i] = (state != TWO);
        assign wb_valid[i]    = (state != EMPTY);
        assign wb_phys_rd[i]  = out_rd;
        assign wb_data[i]     = out_data;
    end

`ifdef ALU_EXEC_PERF_CNT_EN
    logic [31:0] exec_inc, stall_inc;

    always_comb begin
        exec_inc  = 32'd0;
        stall_inc = 32'd0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            exec_inc  = exec_inc + 32'(wb_valid[i] && wb_ready[i]);
            stall_inc = stall_inc + 32'(issue_valid[i] && !issue_ready[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_exec_count  <= 32'd0;
            perf_stall_count <= 32'd0;
        end else begin
            perf_exec_count  <= perf_exec_count + exec_inc;
            perf_stall_count <= perf_stall_count + stall_inc;
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage: directed scenarios plus randomized
// traffic checked against a per-lane queue model.
module tb_alu_exec_stage;
    import common::*;

    localparam int DW = parameters::DISPATCH_WIDTH;
    localparam int AW = parameters::PHYS_REGS_ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid   [DW];
    logic          issue_ready   [DW];
    alu_cmd_t      issue_alu_cmd [DW];
    logic [31:0]   issue_op1     [DW];
    logic [31:0]   issue_op2     [DW];
    logic [AW-1:0] issue_phys_rd [DW];
    logic          wb_valid      [DW];
    logic          wb_ready      [DW];
    logic [AW-1:0] wb_phys_rd    [DW];
    logic [31:0]   wb_data       [DW];
`ifdef ALU_EXEC_PERF_CNT_EN
    logic [31:0]   perf_exec_count;
    logic [31:0]   perf_stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] rd;
        logic [31:0]   data;
    } beat_t;

    beat_t       mq [DW][$];
    logic [31:0] exp_exec  = 0;
    logic [31:0] exp_stall = 0;

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_alu_cmd (issue_alu_cmd),
        .issue_op1     (issue_op1),
        .issue_op2     (issue_op2),
        .issue_phys_rd (issue_phys_rd),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_phys_rd    (wb_phys_rd),
        .wb_data       (wb_data)
`ifdef ALU_EXEC_PERF_CNT_EN
        ,
        .perf_exec_count  (perf_exec_count),
        .perf_stall_count (perf_stall_count)
`endif
    );

    function automatic logic [31:0] ref_alu(alu_cmd_t c, logic [31:0] a, logic [31:0] b);
        int          sa;
        int          sb;
        int unsigned sh;
        sa = a;
        sb = b;
        sh = 32'(b[4:0]);
        case (c)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a + (~b) + 32'd1;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'h0;
        endcase
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        bit          xf [DW];
        bit          ac [DW];
        beat_t       nb [DW];
        logic [31:0] nx, ns;
        nx = 0;
        ns = 0;
        for (int l = 0; l < DW; l++) begin
            xf[l] = (mq[l].size() > 0) && wb_ready[l];
            ac[l] = issue_valid[l] && (mq[l].size() < 2);
            if (xf[l]) nx++;
            if (issue_valid[l] && mq[l].size() == 2) ns++;
            nb[l].rd   = issue_phys_rd[l];
            nb[l].data = ref_alu(issue_alu_cmd[l], issue_op1[l], issue_op2[l]);
        end
        @(posedge clk);
        for (int l = 0; l < DW; l++) begin
            if (!rst) begin
                mq[l].delete();
            end else begin
                if (xf[l]) void'(mq[l].pop_front());
                if (ac[l]) mq[l].push_back(nb[l]);
            end
        end
        if (!rst) begin
            exp_exec  = 0;
            exp_stall = 0;
        end else begin
            exp_exec  = exp_exec + nx;
            exp_stall = exp_stall + ns;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int l = 0; l < DW; l++) begin
            issue_valid[l]   = 1'b0;
            issue_alu_cmd[l] = ALU_ADD;
            issue_op1[l]     = 32'h0;
            issue_op2[l]     = 32'h0;
            issue_phys_rd[l] = '0;
            wb_ready[l]      = 1'b1;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic set_op(int l, alu_cmd_t c, logic [31:0] a, logic [31:0] b, logic [AW-1:0] rd);
        issue_valid[l]   = 1'b1;
        issue_alu_cmd[l] = c;
        issue_op1[l]     = a;
        issue_op2[l]     = b;
        issue_phys_rd[l] = rd;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        for (int l = 0; l < DW; l++) begin
            checks++;
            if (wb_valid[l] !== 1'b0) begin
                failures++;
                $display("FAIL reset_wb_valid lane%0d got=%b exp=0", l, wb_valid[l]);
            end
            checks++;
            if (issue_ready[l] !== 1'b1) begin
                failures++;
                $display("FAIL reset_issue_ready lane%0d got=%b exp=1", l, issue_ready[l]);
            end
            checks++;
            if (wb_phys_rd[l] !== '0 || wb_data[l] !== 32'h0) begin
                failures++;
                $display("FAIL reset_wb_zero lane%0d rd=%0d data=%h exp=0", l, wb_phys_rd[l], wb_data[l]);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_add_latency();
        do_reset();
        set_op(0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, AW'(5));
        tick();
        issue_valid[0] = 1'b0;
        checks++;
        if (wb_valid[0] !== 1'b1 || wb_phys_rd[0] !== AW'(5) || wb_data[0] !== 32'h0) begin
            failures++;
            $display("FAIL add_beat got v=%b rd=%0d d=%h exp v=1 rd=5 d=0",
                     wb_valid[0], wb_phys_rd[0], wb_data[0]);
        end
        tick();
        checks++;
        if (wb_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL add_after got=%b exp=0", wb_valid[0]);
        end
    endtask

    task automatic test_alu_ops();
        alu_cmd_t    cmds [4];
        logic [31:0] exp  [4];
        do_reset();
        cmds[0] = ALU_SRA;  exp[0] = 32'hF800_0000;
        cmds[1] = ALU_SLT;  exp[1] = 32'd1;
        cmds[2] = ALU_SLTU; exp[2] = 32'd0;
        cmds[3] = alu_cmd_t'(4'd13); exp[3] = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) set_op(1, cmds[k], 32'h8000_0000, 32'h0000_0024, AW'(k + 8));
            else        set_op(1, cmds[k], 32'hFFFF_FFFF, 32'd1, AW'(k + 8));
            tick();
            issue_valid[1] = 1'b0;
            checks++;
            if (wb_valid[1] !== 1'b1 || wb_phys_rd[1] !== AW'(k + 8) || wb_data[1] !== exp[k]) begin
                failures++;
                $display("FAIL alu_op%0d got v=%b rd=%0d d=%h exp v=1 rd=%0d d=%h",
                         k, wb_valid[1], wb_phys_rd[1], wb_data[1], k + 8, exp[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] got [$];
        bool_dummy: begin end
        do_reset();
        wb_ready[0] = 1'b0;
        set_op(0, ALU_OR, 32'h1, 32'h10, AW'(1));
        tick();
        set_op(0, ALU_OR, 32'h2, 32'h20, AW'(2));
        tick();
        set_op(0, ALU_OR, 32'h3, 32'h30, AW'(3));
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (issue_ready[0] !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready cyc%0d got=%b exp=0", c, issue_ready[0]);
            end
            checks++;
            if (wb_valid[0] !== 1'b1 || wb_phys_rd[0] !== AW'(1) || wb_data[0] !== 32'h11) begin
                failures++;
                $display("FAIL bp_hold cyc%0d got v=%b rd=%0d d=%h exp v=1 rd=1 d=11",
                         c, wb_valid[0], wb_phys_rd[0], wb_data[0]);
            end
            tick();
        end
        wb_ready[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bit acc;
            if (wb_valid[0] && wb_ready[0]) got.push_back(wb_phys_rd[0]);
            acc = issue_valid[0] && issue_ready[0];
            tick();
            if (acc) issue_valid[0] = 1'b0;
        end
        checks++;
        if (got.size() != 3 || got[0] !== AW'(1) || got[1] !== AW'(2) || got[2] !== AW'(3)) begin
            failures++;
            $display("FAIL bp_order got n=%0d seq=%p exp 1,2,3", got.size(), got);
        end
    endtask

    task automatic test_back_to_back();
        int bad_ready, bad_beat;
        do_reset();
        bad_ready = 0;
        bad_beat  = 0;
        for (int c = 0; c < 20; c++) begin
            for (int l = 0; l < DW; l++)
                set_op(l, ALU_ADD, 32'(c), 32'(l * 100), AW'(c));
            if (c > 0) begin
                for (int l = 0; l < DW; l++) begin
                    if (issue_ready[l] !== 1'b1) bad_ready++;
                    if (wb_valid[l] !== 1'b1 || wb_data[l] !== 32'(c - 1 + l * 100)
                        || wb_phys_rd[l] !== AW'(c - 1)) bad_beat++;
                end
            end
            tick();
        end
        checks++;
        if (bad_ready != 0) begin
            failures++;
            $display("FAIL b2b_ready stalls=%0d exp=0", bad_ready);
        end
        checks++;
        if (bad_beat != 0) begin
            failures++;
            $display("FAIL b2b_beats bad=%0d exp=0", bad_beat);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_op();
        int stale;
        do_reset();
        wb_ready[0] = 1'b0;
        set_op(0, ALU_XOR, 32'hA, 32'h5, AW'(7));
        tick();
        set_op(0, ALU_XOR, 32'hB, 32'h5, AW'(8));
        tick();
        idle_inputs();
        wb_ready[0] = 1'b0;
        checks++;
        if (issue_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_full got=%b exp=0", issue_ready[0]);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int l = 0; l < DW; l++) begin
            checks++;
            if (wb_valid[l] !== 1'b0 || issue_ready[l] !== 1'b1) begin
                failures++;
                $display("FAIL mid_reset lane%0d got v=%b r=%b exp v=0 r=1",
                         l, wb_valid[l], issue_ready[l]);
            end
        end
        wb_ready[0] = 1'b1;
        stale = 0;
        for (int c = 0; c < 4; c++) begin
            if (wb_valid[0] !== 1'b0) stale++;
            tick();
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL mid_stale beats=%0d exp=0", stale);
        end
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            for (int l = 0; l < DW; l++) begin
                if (wb_valid[l] !== (mq[l].size() > 0) || issue_ready[l] !== (mq[l].size() < 2)) begin
                    bad++;
                    if (bad < 5) $display("FAIL rand_hs cyc%0d lane%0d v=%b r=%b exp_n=%0d",
                                          c, l, wb_valid[l], issue_ready[l], mq[l].size());
                end else if (mq[l].size() > 0 &&
                             (wb_phys_rd[l] !== mq[l][0].rd || wb_data[l] !== mq[l][0].data)) begin
                    bad++;
                    if (bad < 5) $display("FAIL rand_beat cyc%0d lane%0d rd=%0d d=%h exp rd=%0d d=%h",
                                          c, l, wb_phys_rd[l], wb_data[l], mq[l][0].rd, mq[l][0].data);
                end
                issue_valid[l]   = ($urandom_range(0, 3) != 0);
                issue_alu_cmd[l] = alu_cmd_t'($urandom_range(0, 11));
                issue_op1[l]     = $urandom();
                issue_op2[l]     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
                issue_phys_rd[l] = AW'($urandom());
                wb_ready[l]      = ($urandom_range(0, 2) != 0);
            end
            rst = ($urandom_range(0, 99) != 0);
            tick();
            rst = 1'b1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rand_total mismatches=%0d exp=0", bad);
        end
        idle_inputs();
        tick();
    endtask

`ifdef ALU_EXEC_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        checks++;
        if (perf_exec_count !== 32'd0 || perf_stall_count !== 32'd0) begin
            failures++;
            $display("FAIL perf_reset got e=%0d s=%0d exp 0 0", perf_exec_count, perf_stall_count);
        end
        wb_ready[1] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            set_op(0, ALU_ADD, 32'(c), 32'd1, AW'(c));
            if (c < 5) set_op(1, ALU_SUB, 32'(c), 32'd1, AW'(c));
            else issue_valid[1] = 1'b0;
            tick();
        end
        issue_valid[0] = 1'b0;
        tick();
        checks++;
        if (perf_exec_count !== 32'd10 || perf_stall_count !== 32'd3) begin
            failures++;
            $display("FAIL perf_count got e=%0d s=%0d exp 10 3", perf_exec_count, perf_stall_count);
        end
        checks++;
        if (perf_exec_count !== exp_exec || perf_stall_count !== exp_stall) begin
            failures++;
            $display("FAIL perf_model got e=%0d s=%0d exp %0d %0d",
                     perf_exec_count, perf_stall_count, exp_exec, exp_stall);
        end
        do_reset();
        checks++;
        if (perf_exec_count !== 32'd0 || perf_stall_count !== 32'd0) begin
            failures++;
            $display("FAIL perf_clear got e=%0d s=%0d exp 0 0", perf_exec_count, perf_stall_count);
        end
    endtask
`endif

    initial begin
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_add_latency();
        test_alu_ops();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
`ifdef ALU_EXEC_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
